// File: rtl/pipeline_perf_counter.sv
// pipeline_perf_counter
//   On-chip event monitor for the 5-stage CPU pipeline. Counts run cycles and
//   NUM_CH per-cycle event strobes, stops after CYCLE_LIMIT counted cycles and
//   exposes every counter plus a sticky overflow map through a registered,
//   one-cycle-latency read port.
//   Optional feature macro: PERF_CNT_SNAPSHOT_EN adds shadow registers loaded
//   by snap_i. When the macro is defined, reads return the shadow copy instead
//   of the live counters.
module pipeline_perf_counter #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 64,
   parameter bit SAT_MODE    = 1'b1,
   parameter int AW          = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              clear_i,
   input  logic [NUM_CH-1:0] ev_i,
   input  logic              snap_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic              rd_valid_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(CYCLE_LIMIT);
   localparam logic [AW-1:0]    OVF_ADDR  = AW'(NUM_CH + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] ch_q [NUM_CH];
   logic [CNT_W-1:0] ch_d [NUM_CH];
   logic [NUM_CH:0]  ovf_q, ovf_d;
   logic             count_en;

   // Values presented to the read mux (live or shadow).
   logic [CNT_W-1:0] rd_cycle;
   logic [CNT_W-1:0] rd_ch [NUM_CH];
   logic [NUM_CH:0]  rd_ovf;
   logic [CNT_W-1:0] rd_mux;

   // One increment step: all-ones either sticks or rolls over to zero.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) return SAT_MODE ? CNT_MAX : '0;
      return v + CNT_W'(1);
   endfunction

   // Next FSM state and counter values for the coming edge.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no path infers a latch.
      state_d  = state_q;
      cycle_d  = cycle_q;
      ch_d     = ch_q;
      ovf_d    = ovf_q;
      count_en = (state_q == ST_RUN) && start_i;

      case (state_q)
         ST_IDLE:  if (start_i)  state_d = ST_RUN;
         ST_PAUSE: if (start_i)  state_d = ST_RUN;
         ST_RUN:   if (!start_i) state_d = ST_PAUSE;
         default:  state_d = state_q;
      endcase

      if (count_en) begin
         cycle_d = bump(cycle_q);
         if (cycle_q == CNT_MAX) ovf_d[0] = 1'b1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (ev_i[k]) begin
               ch_d[k] = bump(ch_q[k]);
               if (ch_q[k] == CNT_MAX) ovf_d[k+1] = 1'b1;
            end
         end
         // The edge that reaches the limit still counts its events.
         if (CYCLE_LIMIT != 0 && cycle_d == LIMIT_VAL) state_d = ST_DONE;
      end
   end

   // FSM and counter registers; clear_i overrides any counting on its edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: non-blocking assignments so every flop here sees the pre-edge values.
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cycle_q <= '0;
         ovf_q   <= '0;
         // NOTE: the channel array is flops rather than RAM, so it is async-reset like the rest.
         for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
      end else if (clear_i) begin
         state_q <= ST_IDLE;
         cycle_q <= '0;
         ovf_q   <= '0;
         for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         ovf_q   <= ovf_d;
         ch_q    <= ch_d;
      end
   end

`ifdef PERF_CNT_SNAPSHOT_EN
   logic [CNT_W-1:0] cycle_s;
   logic [CNT_W-1:0] ch_s [NUM_CH];
   logic [NUM_CH:0]  ovf_s;

   // Shadow copy of the post-update counters, loaded on snap_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cycle_s <= '0;
         ovf_s   <= '0;
         for (int k = 0; k < NUM_CH; k++) ch_s[k] <= '0;
      end else if (clear_i) begin
         cycle_s <= '0;
         ovf_s   <= '0;
         for (int k = 0; k < NUM_CH; k++) ch_s[k] <= '0;
      end else if (snap_i) begin
         cycle_s <= cycle_d;
         ovf_s   <= ovf_d;
         ch_s    <= ch_d;
      end
   end

   assign rd_cycle = cycle_s;
   assign rd_ch    = ch_s;
   assign rd_ovf   = ovf_s;
`else
   // Without shadow registers the snapshot strobe has no function.
   logic snap_unused;
   assign snap_unused = snap_i;

   assign rd_cycle = cycle_q;
   assign rd_ch    = ch_q;
   assign rd_ovf   = ovf_q;
`endif

   // Address decode; unmapped addresses read as zero.
   always_comb begin
      rd_mux = '0;
      if (rd_addr_i == '0)
         rd_mux = rd_cycle;
      else if (rd_addr_i == OVF_ADDR)
         rd_mux = CNT_W'(rd_ovf);
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_addr_i == AW'(k + 1)) rd_mux = rd_ch[k];
      end
   end

   // Registered read port: data holds between accepted reads.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= rd_en_i;
         if (rd_en_i) rd_data_o <= rd_mux;
      end
   end

   assign busy_o = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipeline_perf_counter.sv
// tb_pipeline_perf_counter
//   Self-checking bench for pipeline_perf_counter: a directed vector table, a
//   set of multi-cycle corner sequences, and a randomized run compared every
//   cycle against a rule-level reference model. Two extra 8-bit instances
//   cover saturate and wrap behaviour with an unlimited run.
module tb_pipeline_perf_counter;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int LIMIT  = 64;
   localparam int AW     = 4;
   localparam longint unsigned MAXV = (64'd1 << CNT_W) - 64'd1;

`ifdef PERF_CNT_SNAPSHOT_EN
   localparam bit SNAP_EN = 1'b1;
`else
   localparam bit SNAP_EN = 1'b0;
`endif

   // Main instance (default parameters).
   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              start_i = 1'b0, clear_i = 1'b0, snap_i = 1'b0, rd_en_i = 1'b0;
   logic [NUM_CH-1:0] ev_i = '0;
   logic [AW-1:0]     rd_addr_i = '0;
   logic [CNT_W-1:0]  rd_data_o;
   logic              rd_valid_o, busy_o, done_o;

   // Shared stimulus for the two 8-bit instances.
   logic              s_start = 1'b0, s_clear = 1'b0, s_snap = 1'b0, s_rd_en = 1'b0;
   logic [NUM_CH-1:0] s_ev = '0;
   logic [AW-1:0]     s_addr = '0;
   logic [7:0]        sat_data, wrap_data;
   logic              sat_valid, sat_busy, sat_done, wrap_valid, wrap_busy, wrap_done;

   always #5 clk_i = ~clk_i;

   pipeline_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYCLE_LIMIT(LIMIT),
                           .SAT_MODE(1'b1), .AW(AW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .clear_i(clear_i),
      .ev_i(ev_i), .snap_i(snap_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o), .done_o(done_o));

   pipeline_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(8), .CYCLE_LIMIT(0),
                           .SAT_MODE(1'b1), .AW(AW)) dut_sat (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(s_start), .clear_i(s_clear),
      .ev_i(s_ev), .snap_i(s_snap), .rd_en_i(s_rd_en), .rd_addr_i(s_addr),
      .rd_data_o(sat_data), .rd_valid_o(sat_valid), .busy_o(sat_busy), .done_o(sat_done));

   pipeline_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(8), .CYCLE_LIMIT(0),
                           .SAT_MODE(1'b0), .AW(AW)) dut_wrap (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(s_start), .clear_i(s_clear),
      .ev_i(s_ev), .snap_i(s_snap), .rd_en_i(s_rd_en), .rd_addr_i(s_addr),
      .rd_data_o(wrap_data), .rd_valid_o(wrap_valid), .busy_o(wrap_busy), .done_o(wrap_done));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (rule level) ----------------
   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
   mst_t              m_st;
   longint unsigned   m_cyc, s_cyc, m_data;
   longint unsigned   m_ch [NUM_CH];
   longint unsigned   s_ch [NUM_CH];
   bit [NUM_CH:0]     m_ovf, s_ovf;
   bit                m_valid;

   function automatic longint unsigned sat_inc(input longint unsigned v);
      return (v == MAXV) ? MAXV : v + 64'd1;
   endfunction

   function automatic longint unsigned read_val(input int a);
      longint unsigned cyc;
      bit [NUM_CH:0]   ovf;
      cyc = SNAP_EN ? s_cyc : m_cyc;
      ovf = SNAP_EN ? s_ovf : m_ovf;
      if (a == 0) return cyc;
      if (a <= NUM_CH) return SNAP_EN ? s_ch[a-1] : m_ch[a-1];
      if (a == NUM_CH + 1) return longint'(ovf);
      return 0;
   endfunction

   task automatic model_zero();
      m_cyc = 0; s_cyc = 0; m_ovf = '0; s_ovf = '0;
      for (int k = 0; k < NUM_CH; k++) begin m_ch[k] = 0; s_ch[k] = 0; end
      m_st = M_IDLE;
   endtask

   task automatic model_reset();
      model_zero();
      m_valid = 1'b0;
      m_data  = 0;
   endtask

   task automatic model_edge();
      if (rd_en_i) begin
         m_valid = 1'b1;
         m_data  = read_val(int'(rd_addr_i));
      end else begin
         m_valid = 1'b0;
      end
      if (clear_i) begin
         model_zero();
      end else begin
         case (m_st)
            M_IDLE, M_PAUSE: if (start_i) m_st = M_RUN;
            M_RUN: begin
               if (!start_i) m_st = M_PAUSE;
               else begin
                  if (m_cyc == MAXV) m_ovf[0] = 1'b1;
                  m_cyc = sat_inc(m_cyc);
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (ev_i[k]) begin
                        if (m_ch[k] == MAXV) m_ovf[k+1] = 1'b1;
                        m_ch[k] = sat_inc(m_ch[k]);
                     end
                  end
                  if (m_cyc == LIMIT) m_st = M_DONE;
               end
            end
            default: ;
         endcase
         if (SNAP_EN && snap_i) begin
            s_cyc = m_cyc; s_ovf = m_ovf;
            for (int k = 0; k < NUM_CH; k++) s_ch[k] = m_ch[k];
         end
      end
   endtask

   task automatic compare_model();
      check("model busy", busy_o, (m_st == M_RUN || m_st == M_PAUSE));
      check("model done", done_o, (m_st == M_DONE));
      check("model rd_valid", rd_valid_o, m_valid);
      check("model rd_data", rd_data_o, m_data);
   endtask

   // One clock edge: model follows the DUT, outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
      compare_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit              start;
      bit              clear;
      logic [3:0]      ev;
      bit              rd_en;
      logic [3:0]      addr;
      bit              busy;
      bit              done;
      bit              valid;
      longint unsigned data;
   } vec_t;

   vec_t tbl [14];
   int   done_ticks;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            start clr  ev     rd   addr   busy done vld  data
      tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 64'd0};
      tbl[1]  = '{1'b1, 1'b0, 4'hf, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[2]  = '{1'b1, 1'b0, 4'h1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 64'd0};
      tbl[3]  = '{1'b1, 1'b0, 4'h3, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 64'd1};
      tbl[4]  = '{1'b0, 1'b0, 4'hf, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 64'd2};
      tbl[5]  = '{1'b0, 1'b0, 4'hf, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 64'd1};
      tbl[6]  = '{1'b1, 1'b0, 4'hf, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 64'd1};
      tbl[7]  = '{1'b1, 1'b0, 4'h4, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 64'd0};
      tbl[8]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 64'd1};
      tbl[9]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 64'd0};
      tbl[10] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 64'd5};
      tbl[11] = '{1'b1, 1'b1, 4'hf, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 64'd6};
      tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 64'd0};
      tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 64'd0};

      // Reset state.
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check("reset busy", busy_o, 0);
      check("reset done", done_o, 0);
      check("reset rd_valid", rd_valid_o, 0);
      check("reset rd_data", rd_data_o, 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Directed table (no snapshot taken, so shadow reads are zero).
      for (int i = 0; i < 14; i++) begin
         start_i = tbl[i].start; clear_i = tbl[i].clear; ev_i = tbl[i].ev;
         rd_en_i = tbl[i].rd_en; rd_addr_i = tbl[i].addr;
         tick();
         check($sformatf("vec%0d busy", i), busy_o, tbl[i].busy);
         check($sformatf("vec%0d done", i), done_o, tbl[i].done);
         check($sformatf("vec%0d rd_valid", i), rd_valid_o, tbl[i].valid);
         check($sformatf("vec%0d rd_data", i), rd_data_o, SNAP_EN ? 64'd0 : tbl[i].data);
      end
      clear_i = 1'b0; rd_en_i = 1'b0;

      // Reset mid-RUN: outputs drop before the next edge.
      start_i = 1'b1; ev_i = 4'h5; rd_en_i = 1'b1; rd_addr_i = 4'd0;
      repeat (6) tick();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check("midrun reset busy", busy_o, 0);
      check("midrun reset done", done_o, 0);
      check("midrun reset rd_valid", rd_valid_o, 0);
      check("midrun reset rd_data", rd_data_o, 0);
      model_reset();
      start_i = 1'b0; ev_i = '0; rd_en_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Limit run: ev[0] on every other counted edge, then stray events.
      start_i = 1'b1; ev_i = '0;
      tick();
      for (int i = 0; i < LIMIT; i++) begin
         ev_i = {3'b000, (i % 2 == 0)};
         tick();
         if (i == LIMIT - 2) check("limit done early", done_o, 0);
      end
      check("limit done", done_o, 1);
      ev_i = 4'hf;
      repeat (5) tick();
      rd_en_i = 1'b1; rd_addr_i = 4'd0;
      tick();
      check("limit cycle", rd_data_o, SNAP_EN ? 0 : 64);
      rd_addr_i = 4'd1;
      tick();
      check("limit ch0", rd_data_o, SNAP_EN ? 0 : 32);

      // Clear in DONE concurrent with a read returns the pre-clear value.
      clear_i = 1'b1; rd_addr_i = 4'd0;
      tick();
      check("clear read", rd_data_o, SNAP_EN ? 0 : 64);
      check("clear busy", busy_o, 0);
      check("clear done", done_o, 0);
      clear_i = 1'b0; start_i = 1'b0;
      tick();
      check("after clear cycle", rd_data_o, 0);
      rd_en_i = 1'b0; ev_i = '0;

      // Pause for 10 edges mid-run: counts freeze, done is pushed out.
      start_i = 1'b1;
      tick();
      repeat (30) tick();
      start_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("pause busy", busy_o, 1);
      end
      rd_en_i = 1'b1; rd_addr_i = 4'd0;
      tick();
      check("pause frozen cycle", rd_data_o, SNAP_EN ? 0 : 30);
      rd_en_i = 1'b0; start_i = 1'b1;
      done_ticks = 0;
      while (!done_o && done_ticks < 100) begin
         tick();
         done_ticks++;
      end
      // One edge to leave PAUSE, then the remaining 34 counted edges.
      check("pause done delay", done_ticks, 35);

      // Snapshot at cycle 20 then run to the limit.
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      tick();
      for (int i = 1; i <= LIMIT; i++) begin
         snap_i = (i == 20);
         tick();
      end
      snap_i = 1'b0; rd_en_i = 1'b1; rd_addr_i = 4'd0;
      tick();
      check("snapshot cycle", rd_data_o, SNAP_EN ? 20 : 64);
      rd_en_i = 1'b0; start_i = 1'b0;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;

      // 8-bit counters, unlimited run, 300 counted edges of ev[1].
      s_clear = 1'b1;
      tick();
      s_clear = 1'b0; s_start = 1'b1; s_ev = 4'b0010;
      tick();
      for (int i = 0; i < 300; i++) begin
         s_snap = (i == 299);
         tick();
      end
      s_snap = 1'b0; s_start = 1'b0; s_ev = '0; s_rd_en = 1'b1; s_addr = 4'd2;
      tick();
      check("sat ch1", sat_data, 255);
      check("wrap ch1", wrap_data, 44);
      check("sat done", sat_done, 0);
      check("wrap busy", wrap_busy, 1);
      s_addr = 4'd0;
      tick();
      check("sat cycle", sat_data, 255);
      check("wrap cycle", wrap_data, 44);
      // Both the cycle counter (bit 0) and ch1 (bit 2) passed all-ones.
      s_addr = 4'd5;
      tick();
      check("sat ovf", sat_data, 5);
      check("wrap ovf", wrap_data, 5);
      check("wrap rd_valid", wrap_valid, 1);
      check("sat rd_valid", sat_valid, 1);
      s_rd_en = 1'b0;

      // Randomized run against the model.
      for (int i = 0; i < 800; i++) begin
         start_i   = ($urandom_range(0, 9) != 0);
         clear_i   = ($urandom_range(0, 49) == 0);
         snap_i    = ($urandom_range(0, 19) == 0);
         ev_i      = NUM_CH'($urandom);
         rd_en_i   = $urandom_range(0, 1) == 1;
         rd_addr_i = AW'($urandom_range(0, 15));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
